dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single data-memory port between two requesters:
//   - commit-stage store writes (ST/STB/STI, issued at ROB head);
//   - load reads from the ld/str buffer (LDR/LDB/LDI).
// - Latches the granted request, holds address/data stable until dmem_resp, routes the response back.
// - Drains loads cancelled by a pipeline flush; stores at commit are never cancelled.
// PARAMETERS
// DATA_WIDTH    16  memory data width
// ADDR_WIDTH    16  memory address width
// STARVE_LIMIT  4   consecutive store grants with a load waiting before the load is forced through (>=1)
// PORTS
// clk           in   1   clock, rising edge
// reset         in   1   asynchronous, active-high reset
// st_req        in   1   commit store request; held high until st_resp
// st_addr       in   ADDR_WIDTH  store address
// st_wdata      in   DATA_WIDTH  store data
// st_mask       in   2   store byte enable (2'b11 word, 2'b01/2'b10 byte)
// st_resp       out  1   one-cycle pulse: store write completed
// ld_req        in   1   load request; held high until ld_resp or flush
// ld_addr       in   ADDR_WIDTH  load address
// ld_resp       out  1   one-cycle pulse: ld_rdata valid
// ld_rdata      out  DATA_WIDTH  load data; equals dmem_rdata while ld_resp=1
// flush         in   1   misprediction/trap flush; cancels pending/in-flight load
// dmem_read     out  1   memory read strobe
// dmem_write    out  1   memory write strobe
// dmem_address  out  ADDR_WIDTH  latched address
// dmem_wdata    out  DATA_WIDTH  latched write data
// dmem_byte_enable out 2 latched byte mask (2'b11 for reads)
// dmem_resp     in   1   memory completion, one cycle
// dmem_rdata    in   DATA_WIDTH  memory read data
// busy          out  1   state != IDLE
// BEHAVIOUR
// - FSM states IDLE, STORE, LOAD, DRAIN. Reset: state=IDLE, starve_cnt=0, latched addr/data/mask=0;
//   all strobes, st_resp, ld_resp = 0.
// - IDLE -> STORE: st_req=1 and not (ld_req=1 and starve_cnt==STARVE_LIMIT).
// - IDLE -> LOAD: ld_req=1, flush=0, and (st_req=0 or starve_cnt==STARVE_LIMIT).
// - On grant, latch the requester's addr/wdata/mask. Strobes are decoded from state:
//   - STORE: dmem_write=1;
//   - LOAD and DRAIN: dmem_read=1.
// - Grant latency: request seen in IDLE at edge N -> strobe asserted from cycle N+1.
// - STORE: on dmem_resp, st_resp=1 in the same cycle (combinational), next state IDLE.
//   flush is ignored in STORE.
// - LOAD: dmem_resp with flush=0 -> ld_resp=1, ld_rdata=dmem_rdata, next state IDLE.
// - LOAD: flush=1 with no dmem_resp -> DRAIN; flush=1 together with dmem_resp -> IDLE, ld_resp=0 (flush wins).
// - DRAIN: keep dmem_read=1 until dmem_resp; discard the data, ld_resp stays 0, then IDLE.
//   A strobe is never dropped mid-access.
// - IDLE with flush=1: no load grant that cycle; a store may still be granted.
// - One IDLE bubble between consecutive accesses. Peak rate: 1 access per (mem latency + 1) cycles.
// - starve_cnt (saturating, $clog2(STARVE_LIMIT+1) bits), updated at each IDLE grant:
//   - store grant while ld_req=1: +1;
//   - load grant, or ld_req=0 at grant: cleared;
//   - flush: cleared.
// - Requester inputs are sampled only in IDLE; changes while busy have no effect.
// - reset asserted mid-access: immediate return to IDLE, strobes drop asynchronously, no responses.
// TESTING
// - Lone store 0x1000/0xBEEF mask 11, mem latency 3 -> dmem_write high 3 cycles with latched values;
//   st_resp on the resp cycle; busy falls next cycle.
// - Lone load 0x2002, dmem_rdata=0x1234 -> ld_resp pulse with ld_rdata=0x1234, dmem_byte_enable=11.
// - st_req and ld_req held high, STARVE_LIMIT=4 -> grant sequence S,S,S,S,L,S,S,S,S,L...
//   Each response pulses exactly once.
// - flush 1 cycle into a 4-cycle load -> DRAIN; dmem_read held to resp; ld_resp never asserts; IDLE after.
// - flush coincident with dmem_resp in LOAD -> ld_resp=0, IDLE next cycle.
//   flush during STORE -> st_resp still pulses.
// - reset asserted mid-STORE -> dmem_write=0 immediately, busy=0, starve_cnt=0;
//   a new st_req after reset release is granted normally.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester and memory-side signals of the data-memory port arbiter
// master is the arbiter's view; slave is the view of the requesters plus memory.
interface dmem_port_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                  st_req;
   logic [ADDR_WIDTH-1:0] st_addr;
   logic [DATA_WIDTH-1:0] st_wdata;
   logic [1:0]            st_mask;
   logic                  st_resp;
   logic                  ld_req;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic                  ld_resp;
   logic [DATA_WIDTH-1:0] ld_rdata;
   logic                  flush;
   logic                  dmem_read;
   logic                  dmem_write;
   logic [ADDR_WIDTH-1:0] dmem_address;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic [1:0]            dmem_byte_enable;
   logic                  dmem_resp;
   logic [DATA_WIDTH-1:0] dmem_rdata;
   logic                  busy;

   modport master (
      input  st_req, st_addr, st_wdata, st_mask, ld_req, ld_addr, flush, dmem_resp, dmem_rdata,
      output st_resp, ld_resp, ld_rdata, dmem_read, dmem_write, dmem_address, dmem_wdata,
             dmem_byte_enable, busy
   );

   modport slave (
      output st_req, st_addr, st_wdata, st_mask, ld_req, ld_addr, flush, dmem_resp, dmem_rdata,
      input  st_resp, ld_resp, ld_rdata, dmem_read, dmem_write, dmem_address, dmem_wdata,
             dmem_byte_enable, busy
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data-memory port between commit stores and buffered loads
// Stores win the port until a waiting load has lost STARVE_LIMIT grants in a row.
module dmem_port_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 16,
   parameter int STARVE_LIMIT = 4
) (
   input logic                 clk,
   input logic                 reset,
   dmem_port_arbiter_if.master bus
);
   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, STORE, LOAD, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            mask_q, mask_d;
   logic                  load_forced;

   assign load_forced = bus.ld_req && (starve_cnt_q == CNT_MAX);

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      case (state_q)
         IDLE: begin
            if (bus.st_req && !load_forced) begin
               state_d = STORE;
               addr_d  = bus.st_addr;
               wdata_d = bus.st_wdata;
               mask_d  = bus.st_mask;
               if (!bus.ld_req) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q != CNT_MAX) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end
            end else if (bus.ld_req && !bus.flush) begin
               state_d      = LOAD;
               addr_d       = bus.ld_addr;
               mask_d       = 2'b11;
               starve_cnt_d = '0;
            end
         end
         STORE: if (bus.dmem_resp) state_d = IDLE;
         // A flushed load keeps its read strobe in DRAIN so the memory access is never cut short.
         LOAD: begin
            if (bus.dmem_resp) state_d = IDLE;
            else if (bus.flush) state_d = DRAIN;
         end
         DRAIN: if (bus.dmem_resp) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) starve_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
      end
   end

   assign bus.dmem_write       = (state_q == STORE);
   assign bus.dmem_read        = (state_q == LOAD) || (state_q == DRAIN);
   assign bus.busy             = (state_q != IDLE);
   assign bus.dmem_address     = addr_q;
   assign bus.dmem_wdata       = wdata_q;
   assign bus.dmem_byte_enable = mask_q;
   assign bus.st_resp          = (state_q == STORE) && bus.dmem_resp;
   assign bus.ld_resp          = (state_q == LOAD) && bus.dmem_resp && !bus.flush;
   assign bus.ld_rdata         = bus.ld_resp ? bus.dmem_rdata : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized and directed bench for dmem_port_arbiter against a transaction model
// The model tracks the access in flight and the store streak; a negedge process compares every cycle.
module tb_dmem_port_arbiter;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus();

   dmem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // model: kind 0 none, 1 store, 2 load, 3 cancelled load still occupying the port
   int          m_kind = 0;
   logic [15:0] m_addr;
   logic [15:0] m_wdata;
   logic [1:0]  m_mask;
   int          m_streak = 0;
   bit          m_new, st_done, ld_done;
   bit          grants[$];

   int          lat = 1, age = 0, fix_lat = 1;
   bit          rand_lat = 0, rand_data = 1;
   logic [15:0] fix_rdata = 16'h0;
   bit          chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_kind = 0;
      m_streak = 0;
      m_addr = '0;
      m_wdata = '0;
      m_mask = '0;
   endtask

   task automatic model_update();
      st_done = 0;
      ld_done = 0;
      m_new = 0;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_kind == 0) begin
         if (bus.st_req && !(bus.ld_req && m_streak == LIMIT)) begin
            m_kind = 1; m_addr = bus.st_addr; m_wdata = bus.st_wdata; m_mask = bus.st_mask;
            m_new = 1; grants.push_back(1'b0);
            m_streak = bus.ld_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
         end else if (bus.ld_req && !bus.flush) begin
            m_kind = 2; m_addr = bus.ld_addr; m_mask = 2'b11;
            m_new = 1; grants.push_back(1'b1);
            m_streak = 0;
         end
      end else if (bus.dmem_resp) begin
         st_done = (m_kind == 1);
         ld_done = (m_kind == 2) && !bus.flush;
         m_kind = 0;
      end else if (m_kind == 2 && bus.flush) begin
         m_kind = 3;
      end
      if (bus.flush) m_streak = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      if (st_done) bus.st_req = 1'b0;
      if (ld_done || bus.flush) bus.ld_req = 1'b0;
      bus.flush = 1'b0;
      if (m_kind != 0) begin
         if (m_new) begin
            age = 1;
            lat = rand_lat ? int'($urandom_range(1, 4)) : fix_lat;
         end else begin
            age++;
         end
      end else begin
         age = 0;
      end
      bus.dmem_resp = (m_kind != 0) && (age == lat);
      bus.dmem_rdata = rand_data ? 16'($urandom) : fix_rdata;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 100 && (m_kind != 0 || bus.st_req || bus.ld_req); i++) step();
      chk("drain_timeout", (m_kind != 0) || bus.st_req || bus.ld_req, 0);
   endtask

   task automatic hold_both();
      if (!bus.st_req) begin
         bus.st_req = 1'b1;
         bus.st_addr = 16'($urandom);
         bus.st_wdata = 16'($urandom);
      end
      if (!bus.ld_req) begin
         bus.ld_req = 1'b1;
         bus.ld_addr = 16'($urandom);
      end
   endtask

   function automatic logic [1:0] pick_mask();
      case ($urandom_range(0, 2))
         0: return 2'b11;
         1: return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", bus.busy, m_kind != 0);
         chk("dmem_write", bus.dmem_write, m_kind == 1);
         chk("dmem_read", bus.dmem_read, m_kind >= 2);
         chk("st_resp", bus.st_resp, (m_kind == 1) && bus.dmem_resp);
         chk("ld_resp", bus.ld_resp, (m_kind == 2) && bus.dmem_resp && !bus.flush);
         if (m_kind != 0) begin
            chk("dmem_address", bus.dmem_address, m_addr);
            chk("dmem_byte_enable", bus.dmem_byte_enable, m_mask);
         end
         if (m_kind == 1) chk("dmem_wdata", bus.dmem_wdata, m_wdata);
         if (m_kind == 2 && bus.dmem_resp && !bus.flush) chk("ld_rdata", bus.ld_rdata, bus.dmem_rdata);
      end
   end

   initial begin
      int nw, nr, nl, nrd;
      logic busy_after;
      logic [9:0] seq10;
      logic [4:0] seq5;

      reset = 1'b1;
      bus.st_req = 0; bus.st_addr = 0; bus.st_wdata = 0; bus.st_mask = 0;
      bus.ld_req = 0; bus.ld_addr = 0; bus.flush = 0;
      bus.dmem_resp = 0; bus.dmem_rdata = 0;
      chk_en = 1;
      step();
      step();
      chk("reset_address", bus.dmem_address, 16'h0);
      chk("reset_wdata", bus.dmem_wdata, 16'h0);
      chk("reset_mask", bus.dmem_byte_enable, 2'b00);
      chk("reset_busy", bus.busy, 1'b0);
      reset = 1'b0;

      // lone store, memory latency 3
      fix_lat = 3;
      bus.st_req = 1; bus.st_addr = 16'h1000; bus.st_wdata = 16'hBEEF; bus.st_mask = 2'b11;
      step();
      nw = 0; nr = 0; busy_after = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.dmem_write) nw++;
         if (bus.st_resp) begin
            nr++;
            chk("store_address", bus.dmem_address, 16'h1000);
            chk("store_wdata", bus.dmem_wdata, 16'hBEEF);
            chk("store_mask", bus.dmem_byte_enable, 2'b11);
         end
         if (i == 3) busy_after = bus.busy;
         step();
      end
      chk("store_write_cycles", nw, 3);
      chk("store_resp_count", nr, 1);
      chk("store_busy_fall", busy_after, 1'b0);
      idle_all();

      // lone load
      fix_lat = 2; rand_data = 0; fix_rdata = 16'h1234;
      bus.ld_req = 1; bus.ld_addr = 16'h2002;
      step();
      nl = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.ld_resp) begin
            nl++;
            chk("load_rdata", bus.ld_rdata, 16'h1234);
            chk("load_mask", bus.dmem_byte_enable, 2'b11);
            chk("load_address", bus.dmem_address, 16'h2002);
         end
         step();
      end
      chk("load_resp_count", nl, 1);
      rand_data = 1;
      idle_all();

      // both requesters held: stores win until the load has waited LIMIT grants
      grants.delete(); fix_lat = 1;
      hold_both();
      for (int i = 0; i < 200 && grants.size() < 10; i++) begin
         step();
         hold_both();
      end
      chk("grant_count", grants.size() >= 10, 1'b1);
      seq10 = '0;
      for (int i = 0; i < 10; i++) seq10 = {seq10[8:0], (i < grants.size()) ? grants[i] : 1'b0};
      chk("grant_sequence", seq10, 10'b0000100001);
      idle_all();

      // flush one cycle into a 4-cycle load
      fix_lat = 4;
      bus.ld_req = 1; bus.ld_addr = 16'h3000;
      step();
      bus.flush = 1;
      nrd = 0; nl = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.dmem_read) nrd++;
         if (bus.ld_resp) nl++;
         step();
      end
      chk("drain_read_cycles", nrd, 4);
      chk("drain_no_resp", nl, 0);
      chk("drain_idle", bus.busy, 1'b0);
      idle_all();

      // flush together with dmem_resp on a load; then flush during a store
      fix_lat = 2;
      bus.ld_req = 1; bus.ld_addr = 16'h4000;
      step();
      step();
      bus.flush = 1;
      @(negedge clk);
      chk("flush_resp_ld_resp", bus.ld_resp, 1'b0);
      step();
      @(negedge clk);
      chk("flush_resp_idle", bus.busy, 1'b0);
      bus.st_req = 1; bus.st_addr = 16'h5000; bus.st_wdata = 16'h0A0A; bus.st_mask = 2'b01;
      step();
      bus.flush = 1;
      step();
      bus.flush = 1;
      @(negedge clk);
      chk("flush_store_resp", bus.st_resp, 1'b1);
      idle_all();

      // reset in the middle of the third store of a streak; the streak must restart
      grants.delete(); fix_lat = 4; bus.st_mask = 2'b11;
      hold_both();
      for (int i = 0; i < 100 && grants.size() < 3; i++) begin
         step();
         hold_both();
      end
      step();
      #2;
      reset = 1'b1;
      model_reset();
      bus.dmem_resp = 0; bus.st_req = 0; bus.ld_req = 0;
      #1;
      chk("reset_mid_write", bus.dmem_write, 1'b0);
      chk("reset_mid_busy", bus.busy, 1'b0);
      step();
      step();
      reset = 1'b0;
      grants.delete(); fix_lat = 1;
      hold_both();
      for (int i = 0; i < 100 && grants.size() < 5; i++) begin
         step();
         hold_both();
      end
      seq5 = '0;
      for (int i = 0; i < 5; i++) seq5 = {seq5[3:0], (i < grants.size()) ? grants[i] : 1'b0};
      chk("post_reset_sequence", seq5, 5'b00001);
      idle_all();

      // random traffic
      rand_lat = 1;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!bus.st_req && $urandom_range(0, 2) == 0) bus.st_req = 1;
         if (!bus.ld_req && $urandom_range(0, 2) == 0) bus.ld_req = 1;
         bus.st_addr = 16'($urandom);
         bus.st_wdata = 16'($urandom);
         bus.st_mask = pick_mask();
         bus.ld_addr = 16'($urandom);
         bus.flush = ($urandom_range(0, 9) == 0);
      end
      idle_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
